// File: rtl/cdb_issue_scheduler_pkg.sv
// Shared types and default latencies for the CDB issue scheduler.
// Execution-unit ids double as CDB owner codes.
package cdb_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_MULT = 2'd1,
        UNIT_DIV  = 2'd2,
        UNIT_MEM  = 2'd3
    } exec_unit_e;

    localparam int DEF_INT_LAT  = 1;
    localparam int DEF_MULT_LAT = 3;
    localparam int DEF_DIV_LAT  = 6;
    localparam int DEF_MEM_LAT  = 1;

    function automatic int max_lat4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cdb_reservation_reg.sv
// CDB reservation shift register: slot[k]/owner[k] describe the CDB k cycles ahead.
// New reservations are indexed by latency and land one position lower after the clock.
module cdb_reservation_reg
    import cdb_issue_scheduler_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEPTH-1:1]      load_slot,
    input  logic [DEPTH-1:1][1:0] load_owner,
    output logic [DEPTH-1:0]      slot,
    output logic [1:0]            head_owner
);

    logic [DEPTH-1:0][1:0] owner;
    logic [DEPTH-1:0]      slot_next;
    logic [DEPTH-1:0][1:0] owner_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH - 1; gi++) begin : g_shift
            assign slot_next[gi]  = slot[gi+1] | load_slot[gi+1];
            assign owner_next[gi] = load_slot[gi+1] ? load_owner[gi+1] : owner[gi+1];
        end
    endgenerate

    assign slot_next[DEPTH-1]  = 1'b0;
    assign owner_next[DEPTH-1] = UNIT_INT;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [2:0] stage_q;
            ffd_param #(.WIDTH(3)) u_ff (
                .clk   (clk),
                .rst_n (rst_n),
                .d     ({slot_next[gi], owner_next[gi]}),
                .q     (stage_q)
            );
            assign slot[gi]  = stage_q[2];
            assign owner[gi] = stage_q[1:0];
        end
    endgenerate

    assign head_owner = owner[0];

endmodule

// File: rtl/ffd_param.sv
// Generic width-parameterized D flip-flop with synchronous active-low clear.
module ffd_param #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/cdb_issue_scheduler.sv
// Issue scheduler that grants execution units only when their future CDB cycle is free,
// so at most one result ever drives the common data bus per cycle.
module cdb_issue_scheduler
    import cdb_issue_scheduler_pkg::*;
#(
    parameter int INT_LAT  = DEF_INT_LAT,
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int MEM_LAT  = DEF_MEM_LAT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_ready,
    input  logic       mult_ready,
    input  logic       div_ready,
    input  logic       mem_ready,
    output logic       int_issue_granted,
    output logic       mult_issue_granted,
    output logic       div_issue_granted,
    output logic       mem_issue_granted,
    output logic [1:0] cdb_sel,
    output logic       cdb_sel_valid
);

    localparam int MAX_LAT = max_lat4(INT_LAT, MULT_LAT, DIV_LAT, MEM_LAT);

    logic [MAX_LAT:0]      slot;
    logic [1:0]            head_owner;
    logic [MAX_LAT:1]      occ;
    logic [MAX_LAT:1]      res_slot;
    logic [MAX_LAT:1][1:0] res_owner;
    logic [2:0]            div_cnt_reg, div_cnt_next;
    logic                  lru_reg, lru_next;
    logic                  int_g, mult_g, div_g, mem_g;

    // Priority chain: each grant marks its slot busy before the next unit looks.
    always_comb begin
        occ    = slot[MAX_LAT:1];
        int_g  = 1'b0;
        mem_g  = 1'b0;
        div_g  = rst_n && div_ready && (div_cnt_reg == 3'd0) && !occ[DIV_LAT];
        if (div_g) occ[DIV_LAT] = 1'b1;
        mult_g = rst_n && mult_ready && !occ[MULT_LAT];
        if (mult_g) occ[MULT_LAT] = 1'b1;
        if (lru_reg) begin
            mem_g = rst_n && mem_ready && !occ[MEM_LAT];
            if (mem_g) occ[MEM_LAT] = 1'b1;
            int_g = rst_n && int_ready && !occ[INT_LAT];
        end else begin
            int_g = rst_n && int_ready && !occ[INT_LAT];
            if (int_g) occ[INT_LAT] = 1'b1;
            mem_g = rst_n && mem_ready && !occ[MEM_LAT];
        end
    end

    // Granted latencies never collide, so the loads can be merged without priority.
    always_comb begin
        res_slot  = '0;
        res_owner = '0;
        if (div_g)  begin res_slot[DIV_LAT]  = 1'b1; res_owner[DIV_LAT]  = UNIT_DIV;  end
        if (mult_g) begin res_slot[MULT_LAT] = 1'b1; res_owner[MULT_LAT] = UNIT_MULT; end
        if (int_g)  begin res_slot[INT_LAT]  = 1'b1; res_owner[INT_LAT]  = UNIT_INT;  end
        if (mem_g)  begin res_slot[MEM_LAT]  = 1'b1; res_owner[MEM_LAT]  = UNIT_MEM;  end
    end

    always_comb begin
        lru_next = lru_reg;
        if (int_g && mem_g) lru_next = ~lru_reg;
        else if (int_g)     lru_next = 1'b1;
        else if (mem_g)     lru_next = 1'b0;

        div_cnt_next = 3'd0;
        if (div_g)                   div_cnt_next = 3'(DIV_LAT - 1);
        else if (div_cnt_reg != 3'd0) div_cnt_next = div_cnt_reg - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lru_reg     <= 1'b0;
            div_cnt_reg <= 3'd0;
        end else begin
            lru_reg     <= lru_next;
            div_cnt_reg <= div_cnt_next;
        end
    end

    cdb_reservation_reg #(.DEPTH(MAX_LAT + 1)) u_resv (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_slot  (res_slot),
        .load_owner (res_owner),
        .slot       (slot),
        .head_owner (head_owner)
    );

    assign int_issue_granted  = int_g;
    assign mult_issue_granted = mult_g;
    assign div_issue_granted  = div_g;
    assign mem_issue_granted  = mem_g;
    assign cdb_sel            = head_owner;
    assign cdb_sel_valid      = slot[0];

endmodule
